// File: rtl/uart_tx.sv
// UART serial transmitter: one byte per valid/ready handshake, framed as
// start bit, data LSB-first, optional parity, then STOP_BITS stop bits.
// Bit timing comes from a fixed integer clock divisor (CLK_DIV clk cycles per bit).
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit after the data
// bits (PARITY_ODD selects odd parity). Without it the frame has no parity bit.
module uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_baud_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
  logic                 w_bit_end;

`ifdef UART_TX_PARITY_EN
  logic r_parity;
  logic w_parity_next;

  // Parity of the byte being accepted, folded with the configured sense.
  assign w_parity_next = (^tx_data) ^ 1'(PARITY_ODD);
`else
  logic w_unused_parity_odd;

  // Parity sense has no effect when the parity bit is not compiled in.
  assign w_unused_parity_odd = 1'(PARITY_ODD);
`endif

  // Last clk cycle of the current serial bit.
  assign w_bit_end = (r_baud_cnt == CNT_LAST);

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign busy     = r_busy;

  // Frame sequencer: state, baud timing, shifting and the registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // tx_ready is high exactly while idle, so tx_valid alone is the handshake here.
          if (tx_valid) begin
            r_state    <= S_START;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= tx_data;
            r_tx       <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_next;
`endif
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_state    <= S_DATA;
            r_baud_cnt <= '0;
            r_tx       <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_shift    <= {1'b0, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == DATA_LAST) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= S_PARITY;
              r_tx      <= r_parity;
`else
              r_state   <= S_STOP;
              r_tx      <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state    <= S_STOP;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          // Bit index is reused to count stop bits.
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == STOP_LAST) begin
              r_bit_idx <= '0;
              r_state   <= S_IDLE;
              r_tx      <= 1'b1;
              r_ready   <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
          r_tx       <= 1'b1;
          r_ready    <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations side by side, a hand-written table of
// frames, random frames against a frame-level model, back-to-back and reset cases.
module tb_uart_tx;

  localparam int unsigned N_DUT = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] td  [N_DUT];
  logic       tv  [N_DUT];
  logic       txo [N_DUT];
  logic       rdy [N_DUT];
  logic       bsy [N_DUT];

  int total;
  int bad;

  bit cap_q[$];
  bit m_q[$];
  int cap_ready_low;
  bit cap_end_tx;
  bit cap_end_rdy;
  bit cap_timeout;

  typedef struct {
    int          s;
    logic [7:0]  d;
    logic [15:0] lvls;
    int          flen;
  } vec_t;

  vec_t tbl[4];

  uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(td[0]), .tx_valid(tv[0]),
    .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]));

  uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(td[1]), .tx_valid(tv[1]),
    .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]));

  uart_tx #(.CLK_DIV(2), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(td[2]), .tx_valid(tv[2]),
    .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_cd(input int s);
    return (s == 2) ? 2 : 4;
  endfunction

  function automatic int cfg_sb(input int s);
    return (s == 2) ? 2 : 1;
  endfunction

  function automatic int cfg_po(input int s);
    return (s == 1) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Serial levels of one frame, one entry per bit (not per clk).
  task automatic model_levels(input int s, input logic [7:0] d);
    m_q.delete();
    m_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) m_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    m_q.push_back(bit'((^d) ^ cfg_po(s)[0]));
`endif
    for (int i = 0; i < cfg_sb(s); i++) m_q.push_back(1'b1);
  endtask

  // Handshake one byte, then record tx on every busy cycle.
  task automatic send_capture(input int s, input logic [7:0] d);
    int w;
    w = 0;
    cap_q.delete();
    cap_ready_low = 0;
    cap_timeout = 1'b0;
    cap_end_tx = 1'b0;
    cap_end_rdy = 1'b0;
    @(negedge clk);
    while (!rdy[s] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!rdy[s]) begin
      check("ready_wait", 0, 1);
      cap_timeout = 1'b1;
      return;
    end
    td[s] = d;
    tv[s] = 1'b1;
    @(posedge clk);
    #1;
    tv[s] = 1'b0;
    td[s] = 8'($urandom);
    cap_timeout = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bsy[s]) begin
        cap_end_tx = txo[s];
        cap_end_rdy = rdy[s];
        cap_timeout = 1'b0;
        break;
      end
      cap_q.push_back(txo[s]);
      if (!rdy[s]) cap_ready_low++;
    end
    if (cap_timeout) check("busy_timeout", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int idle_err;
    int cd;
    int hold_err;
    int mism;
    int f;
    int elen;
    int start2;
    bit gap_rdy;
    logic [15:0] vec;
    bit seq[$];
    bit e_q[$];

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < int'(N_DUT); i++) begin
      td[i] = 8'h00;
      tv[i] = 1'b0;
    end

`ifdef UART_TX_PARITY_EN
    tbl[0] = '{0, 8'hA5, 16'h054A, 44};
    tbl[1] = '{0, 8'h07, 16'h060E, 44};
    tbl[2] = '{1, 8'hA5, 16'h074A, 44};
    tbl[3] = '{2, 8'h81, 16'h0D02, 24};
`else
    tbl[0] = '{0, 8'hA5, 16'h034A, 40};
    tbl[1] = '{0, 8'h07, 16'h020E, 40};
    tbl[2] = '{1, 8'hA5, 16'h034A, 40};
    tbl[3] = '{2, 8'h81, 16'h0702, 22};
`endif

    // Reset and idle.
    idle_err = 0;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < int'(N_DUT); i++)
        if (txo[i] !== 1'b1 || rdy[i] !== 1'b1 || bsy[i] !== 1'b0) idle_err++;
    end
    rst_n = 1'b1;
    check("reset_tx", int'(txo[0]), 1);
    check("reset_ready", int'(rdy[0]), 1);
    check("reset_busy", int'(bsy[0]), 0);
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < int'(N_DUT); i++)
        if (txo[i] !== 1'b1 || rdy[i] !== 1'b1 || bsy[i] !== 1'b0) idle_err++;
    end
    check("reset_idle", idle_err, 0);

    // Directed frames from the table.
    for (int t = 0; t < 4; t++) begin
      cd = cfg_cd(tbl[t].s);
      send_capture(tbl[t].s, tbl[t].d);
      vec = '0;
      hold_err = 0;
      for (int k = 0; k < cap_q.size(); k++) begin
        if (k % cd == 0) begin
          if (k / cd < 16) vec[k / cd] = cap_q[k];
        end else if (cap_q[k] != cap_q[k - (k % cd)]) begin
          hold_err++;
        end
      end
      check($sformatf("tbl%0d_busy_len", t), cap_q.size(), tbl[t].flen);
      check($sformatf("tbl%0d_ready_low", t), cap_ready_low, tbl[t].flen);
      check($sformatf("tbl%0d_levels", t), int'(vec), int'(tbl[t].lvls));
      check($sformatf("tbl%0d_hold", t), hold_err, 0);
      check($sformatf("tbl%0d_end_ready", t), int'(cap_end_rdy), 1);
      check($sformatf("tbl%0d_end_tx", t), int'(cap_end_tx), 1);
    end

    // Random frames against the frame-level model.
    for (int r = 0; r < 24; r++) begin
      int s;
      logic [7:0] d;
      s = int'($urandom_range(0, 2));
      d = 8'($urandom);
      cd = cfg_cd(s);
      model_levels(s, d);
      send_capture(s, d);
      elen = m_q.size() * cd;
      mism = 0;
      for (int k = 0; k < cap_q.size() && k < elen; k++)
        if (cap_q[k] != m_q[k / cd]) mism++;
      check($sformatf("rand%0d_len", r), cap_q.size(), elen);
      check($sformatf("rand%0d_bits", r), mism, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Back-to-back with tx_valid held and tx_data changed mid-frame.
    model_levels(0, 8'h00);
    f = m_q.size() * 4;
    e_q.delete();
    for (int k = 0; k < f; k++) e_q.push_back(m_q[k / 4]);
    e_q.push_back(1'b1);
    model_levels(0, 8'hFF);
    for (int k = 0; k < f; k++) e_q.push_back(m_q[k / 4]);
    while (e_q.size() < 2 * f + 12) e_q.push_back(1'b1);
    seq.delete();
    gap_rdy = 1'b0;
    @(negedge clk);
    check("b2b_ready_before", int'(rdy[0]), 1);
    td[0] = 8'h00;
    tv[0] = 1'b1;
    for (int c = 0; c < 2 * f + 12; c++) begin
      @(negedge clk);
      seq.push_back(txo[0]);
      if (c == f) gap_rdy = rdy[0];
      if (c == 0) td[0] = 8'hFF;
      if (c == f + 1) tv[0] = 1'b0;
    end
    tv[0] = 1'b0;
    mism = 0;
    for (int k = 0; k < 2 * f + 12; k++)
      if (seq[k] != e_q[k]) mism++;
    start2 = -1;
    for (int k = f; k < 2 * f + 12; k++)
      if (start2 < 0 && seq[k] == 1'b0) start2 = k;
    check("b2b_seq", mism, 0);
    check("b2b_first_start", int'(seq[0]), 0);
    check("b2b_start_delta", start2, f + 1);
    check("b2b_gap_level", int'(seq[f]), 1);
    check("b2b_gap_ready", int'(gap_rdy), 1);

    // Reset in the middle of data bit 3 of 0x55.
    repeat (4) @(negedge clk);
    td[0] = 8'h55;
    tv[0] = 1'b1;
    @(posedge clk);
    #1;
    tv[0] = 1'b0;
    repeat (18) @(negedge clk);
    check("mid_bit3_level", int'(txo[0]), 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", int'(txo[0]), 1);
    check("async_reset_busy", int'(bsy[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("post_reset_ready", int'(rdy[0]), 1);
    idle_err = 0;
    repeat (60) begin
      @(negedge clk);
      if (txo[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) idle_err++;
    end
    check("post_reset_quiet", idle_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
